inv_key_schedule: RTL and testbench
===================================

# inv_key_schedule

Round-key generator for the AES-128 decryption datapath. It takes the cipher key and expands it forward to the round-10 key. It then walks the schedule backwards, presenting round keys 10 down to 0, one per `next` request, to the decrypt-side AddRoundKey stage. Only the current round key is held, so the block needs no 11-entry key store; each previous key is derived on the fly with the inverse key-expansion step.

## Interface
- No parameters (AES-128 only: Nk=4, Nr=10).
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-low reset.
- `enable` input 1: start a new schedule; samples `key`.
- `key` input 128: cipher key; word w0 = [127:96], byte order per FIPS-197.
- `next` input 1: consumer request to step to the previous round key.
- `round_key` output 128: current round key; 128'd0 whenever `valid`=0.
- `round` output 4: index of `round_key`, 10..0; 4'd0 when idle.
- `valid` output 1: `round_key`/`round` are meaningful.
- `busy` output 1: high in EXPAND and SERVE.
- `done` output 1: one-cycle pulse after round 0 is consumed.

## Operation
- **States:** IDLE, EXPAND, SERVE. All outputs are 0 in reset and in IDLE.
- **IDLE → EXPAND:** on `enable`=1.
  - The working register w is loaded with `key`.
  - The counter is set to i=1.
- **EXPAND:** each cycle applies forward round i, then increments i.
  - n0 = w0 ^ SubWord(RotWord(w3)) ^ Rcon[i].
  - n1 = w1 ^ n0.
  - n2 = w2 ^ n1.
  - n3 = w3 ^ n2.
  - After round 10 the block enters SERVE with `round`=10 and `valid`=1.
- **SERVE, `next`=1 and `round`>0:** computes the previous key in one cycle.
  - p3 = w3 ^ w2.
  - p2 = w2 ^ w1.
  - p1 = w1 ^ w0.
  - p0 = w0 ^ SubWord(RotWord(p3)) ^ Rcon[round].
  - `round` decrements; `valid` stays 1.
- **SERVE, `next`=1 and `round`=0:** goes to IDLE, clears `valid`/`round_key`, and pulses `done`.
- **SERVE, `next`=0:** all outputs hold indefinitely.
- **Rcon[1..10]:** 01,02,04,08,10,20,40,80,1B,36. Rcon occupies the MS byte of the word; the other bytes are 0.
- **SubWord:** uses the forward AES S-box, instantiated as a combinational lookup. One 4-byte SubWord path is shared by EXPAND and SERVE.
- **Arithmetic:** all arithmetic is GF(2) XOR, so there is no carry or width growth. The round counter saturates at 0 and never wraps.
- **Boundary and priority rules:**
  - `enable` has priority over `next` in every state. It aborts any schedule in progress, reloads `key`, and restarts EXPAND at i=1. If this occurs in SERVE, `valid` drops on the following edge and `done` does not pulse.
  - `next` is ignored in IDLE and EXPAND.
  - Asserting `rst` (driving it low) at any point immediately clears state, counters, and all outputs. Operation resumes only after `rst` is released and a new `enable` arrives.

## Timing
- Call the edge that samples `enable`=1 E0.
- Expansion latency is 10 edges (E1..E10), during which `busy`=1 and `valid`=0. `valid` and `round`=10 are visible after E10.
- Each `next` sampled high advances `round_key` on that same edge, giving a throughput of one key per cycle.
- Serving all keys takes 11 `next` pulses. The `done` pulse follows the 11th and lasts exactly one cycle, and `busy` falls together with it.
- There are no combinational paths from inputs to outputs; every output is registered.

## Configuration
- **`INV_KEY_FAST_EN` undefined:** one forward round per EXPAND cycle, so expansion latency is 10 edges.
- **`INV_KEY_FAST_EN` defined:** two chained forward rounds per EXPAND cycle (second S-box path; i advances by 2), so expansion latency is 5 edges.
- SERVE behaviour and key values are identical in both builds.

## Test plan
- **FIPS-197 A.1 key, first two keys:** `key`=2b7e151628aed2a6abf7158809cf4f3c, `enable` one cycle.
  - After 10 edges (5 with the macro): `valid`=1, `round`=10, `round_key`=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - One `next` gives `round`=9, `round_key`=ac7766f319fadc2128d12941575c006e.
- **Full walk-down:** key 000102030405060708090a0b0c0d0e0f.
  - `round_key`=13111d7fe3944a17f307a78b4d2b30c5 at round 10.
  - Hold `next`=1 for 11 cycles: the key at round 0 equals the input key; then `done`=1 for one cycle, then `valid`=`busy`=0.
- **`next` gaps:** random deasserted gaps between `next` pulses; `round_key`/`round` hold stable across each gap.
- **`enable` at round 5:** `valid`→0; the new key's round-10 value appears after the full expansion latency; no `done` pulse.
- **Async reset:** drive `rst`=0 mid-EXPAND and mid-SERVE, asynchronously between edges. All outputs read 0 before the next edge, and `next` is ignored until a fresh `enable`.
- **`next` in IDLE/EXPAND:** no state change, `done` stays 0.

Source files
------------

// File: rtl/inv_key_schedule.sv
// AES-128 decrypt round-key generator: expands the cipher key forward to round 10, then steps it back to round 0, one key per `next`.
// Define INV_KEY_FAST_EN to run two forward rounds per expansion cycle (5-cycle expansion instead of 10).
module inv_key_schedule (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic [127:0] key,
  input  logic         next,
  output logic [127:0] round_key,
  output logic [3:0]   round,
  output logic         valid,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, EXPAND, SERVE} state_t;

`ifdef INV_KEY_FAST_EN
  localparam logic [3:0] STEP   = 4'd2;
  localparam logic [3:0] LAST_I = 4'd9;
`else
  localparam logic [3:0] STEP   = 4'd1;
  localparam logic [3:0] LAST_I = 4'd10;
`endif

  // Stored high-to-low, so S(b) lives at index ~b.
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [31:0] sub_rot(input logic [31:0] x);
    return {SBOX[~x[23:16]], SBOX[~x[15:8]], SBOX[~x[7:0]], SBOX[~x[31:24]]};
  endfunction

  function automatic logic [31:0] rcon(input logic [3:0] i);
    logic [7:0] b;
    case (i)
      4'd1:    b = 8'h01;
      4'd2:    b = 8'h02;
      4'd3:    b = 8'h04;
      4'd4:    b = 8'h08;
      4'd5:    b = 8'h10;
      4'd6:    b = 8'h20;
      4'd7:    b = 8'h40;
      4'd8:    b = 8'h80;
      4'd9:    b = 8'h1b;
      4'd10:   b = 8'h36;
      default: b = 8'h00;
    endcase
    return {b, 24'h0};
  endfunction

  state_t       state_q;
  logic [127:0] w_q;
  logic [3:0]   ctr_q;
  logic         valid_q, busy_q, done_q;

  logic [31:0]  w0, w1, w2, w3, sw_in, x0;
  logic [127:0] fwd1, fwd_key, inv_key;

  assign {w0, w1, w2, w3} = w_q;

  // Forward n0 and inverse p0 share the form w0 ^ SubRot(.) ^ Rcon[ctr]; only the S-box input differs.
  assign sw_in   = (state_q == SERVE) ? (w3 ^ w2) : w3;
  assign x0      = w0 ^ sub_rot(sw_in) ^ rcon(ctr_q);
  assign fwd1    = {x0, x0 ^ w1, x0 ^ w1 ^ w2, x0 ^ w1 ^ w2 ^ w3};
  assign inv_key = {x0, w1 ^ w0, w2 ^ w1, w3 ^ w2};

`ifdef INV_KEY_FAST_EN
  logic [31:0] y0;
  assign y0      = fwd1[127:96] ^ sub_rot(fwd1[31:0]) ^ rcon(ctr_q + 4'd1);
  assign fwd_key = {y0, y0 ^ fwd1[95:64], y0 ^ fwd1[95:64] ^ fwd1[63:32],
                    y0 ^ fwd1[95:64] ^ fwd1[63:32] ^ fwd1[31:0]};
`else
  assign fwd_key = fwd1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      w_q     <= '0;
      ctr_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (enable) begin
      state_q <= EXPAND;
      w_q     <= key;
      ctr_q   <= 4'd1;
      valid_q <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        EXPAND: begin
          w_q <= fwd_key;
          if (ctr_q == LAST_I) begin
            state_q <= SERVE;
            ctr_q   <= 4'd10;
            valid_q <= 1'b1;
          end else begin
            ctr_q <= ctr_q + STEP;
          end
        end
        SERVE: begin
          if (next) begin
            if (ctr_q != 4'd0) begin
              w_q   <= inv_key;
              ctr_q <= ctr_q - 4'd1;
            end else begin
              state_q <= IDLE;
              w_q     <= '0;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign round_key = valid_q ? w_q : '0;
  assign round     = valid_q ? ctr_q : '0;
  assign valid     = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_inv_key_schedule.sv
// Scoreboard bench for inv_key_schedule: expected round keys come from an independent forward key expansion
// built on a computed (GF inverse + affine) S-box.
module tb_inv_key_schedule;

`ifdef INV_KEY_FAST_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 10;
`endif

  logic         clk = 1'b0;
  logic         rst, enable, next;
  logic [127:0] key;
  logic [127:0] round_key;
  logic [3:0]   round;
  logic         valid, busy, done;

  inv_key_schedule dut (
    .clk(clk), .rst(rst), .enable(enable), .key(key), .next(next),
    .round_key(round_key), .round(round), .valid(valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   rnd;
    logic [127:0] k;
  } exp_t;

  exp_t         exp_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           mr       = 0;
  logic [7:0]   sb [0:255];
  logic [127:0] ks [0:10];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xt(aa);
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] x);
    return {x[6:0], x[7]};
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, r, s;
    for (int b = 0; b < 256; b++) begin
      inv = 8'h00;
      for (int x = 1; x < 256; x++)
        if (b != 0 && gmul(8'(b), 8'(x)) == 8'h01) inv = 8'(x);
      s = inv; r = inv;
      for (int k = 0; k < 4; k++) begin
        r = rotl1(r);
        s = s ^ r;
      end
      sb[b] = s ^ 8'h63;
    end
  endtask

  task automatic compute_ks(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Output monitor: pops on every newly presented key, checks stability while held and zeros while invalid.
  logic         pv = 1'b0;
  logic [3:0]   pr = 4'd0;
  logic [127:0] pk = '0;
  always @(negedge clk) begin
    exp_t e;
    if (valid) begin
      if (!pv || round != pr) begin
        if (exp_q.size() == 0) begin
          check_eq("sb_extra_out", 128'(valid), 128'(0));
        end else begin
          e = exp_q.pop_front();
          check_eq("sb_round", 128'(round), 128'(e.rnd));
          check_eq("sb_key", round_key, e.k);
        end
      end else begin
        check_eq("hold_key", round_key, pk);
      end
    end else begin
      check_eq("idle_key_zero", round_key, 128'(0));
      check_eq("idle_round_zero", 128'(round), 128'(0));
    end
    pv = valid; pr = round; pk = round_key;
  end

  task automatic start(input logic [127:0] k);
    exp_t e;
    compute_ks(k);
    key    = k;
    enable = 1'b1;
    e.rnd = 4'd10; e.k = ks[10];
    exp_q.push_back(e);
    mr = 10;
    @(posedge clk); #1;
    enable = 1'b0;
    check_eq("e0_valid", 128'(valid), 128'(0));
    check_eq("e0_busy", 128'(busy), 128'(1));
    check_eq("e0_done", 128'(done), 128'(0));
  endtask

  task automatic wait_expand(input logic nx);
    next = nx;
    for (int c = 1; c < LAT; c++) begin
      @(posedge clk); #1;
      check_eq("exp_busy", 128'(busy), 128'(1));
      check_eq("exp_valid", 128'(valid), 128'(0));
      check_eq("exp_done", 128'(done), 128'(0));
    end
    next = 1'b0;
    @(posedge clk); #1;
    check_eq("serve_valid", 128'(valid), 128'(1));
    check_eq("serve_round", 128'(round), 128'(10));
  endtask

  task automatic step(input int gap);
    exp_t e;
    next = 1'b1;
    if (mr > 0) begin
      e.rnd = 4'(mr - 1); e.k = ks[mr - 1];
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    next = 1'b0;
    if (mr > 0) mr--;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic walk_down(input int maxgap);
    while (mr > 0) step(int'($urandom_range(maxgap, 0)));
    check_eq("r0_is_key", round_key, key);
    check_eq("r0_valid", 128'(valid), 128'(1));
    next = 1'b1;
    @(posedge clk); #1;
    next = 1'b0;
    check_eq("done_pulse", 128'(done), 128'(1));
    check_eq("done_valid", 128'(valid), 128'(0));
    check_eq("done_busy", 128'(busy), 128'(0));
    @(posedge clk); #1;
    check_eq("done_clear", 128'(done), 128'(0));
  endtask

  task automatic async_reset();
    #2 rst = 1'b0;
    exp_q.delete();
    #1;
    check_eq("rst_valid", 128'(valid), 128'(0));
    check_eq("rst_busy", 128'(busy), 128'(0));
    check_eq("rst_done", 128'(done), 128'(0));
    check_eq("rst_key", round_key, 128'(0));
    check_eq("rst_round", 128'(round), 128'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      next = 1'b1;
      @(posedge clk); #1;
      check_eq("idle_next_busy", 128'(busy), 128'(0));
      check_eq("idle_next_valid", 128'(valid), 128'(0));
      check_eq("idle_next_done", 128'(done), 128'(0));
    end
    next = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; enable = 1'b0; next = 1'b0; key = '0;
    build_sbox();
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_valid", 128'(valid), 128'(0));
    check_eq("reset_busy", 128'(busy), 128'(0));
    check_eq("reset_done", 128'(done), 128'(0));
    check_eq("reset_key", round_key, 128'(0));
    rst = 1'b1;
    @(posedge clk); #1;

    // FIPS-197 A.1 key: round 10 and round 9 against published values
    start(128'h2b7e151628aed2a6abf7158809cf4f3c);
    wait_expand(1'b0);
    check_eq("a1_r10", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    step(0);
    check_eq("a1_r9", round_key, 128'hac7766f319fadc2128d12941575c006e);
    check_eq("a1_r9_round", 128'(round), 128'(9));
    walk_down(0);

    // Full back-to-back walk; next held high during expansion must be ignored
    start(128'h000102030405060708090a0b0c0d0e0f);
    wait_expand(1'b1);
    check_eq("c1_r10", round_key, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    walk_down(0);

    // Random keys with random gaps between next pulses
    for (int n = 0; n < 2; n++) begin
      start({$urandom, $urandom, $urandom, $urandom});
      wait_expand(1'b0);
      walk_down(3);
    end

    // Restart while serving round 5: no done, new key expands from scratch
    start({$urandom, $urandom, $urandom, $urandom});
    wait_expand(1'b0);
    repeat (5) step(0);
    check_eq("abort_round5", 128'(round), 128'(5));
    start({$urandom, $urandom, $urandom, $urandom});
    wait_expand(1'b0);
    walk_down(1);

    // Asynchronous reset mid-expansion and mid-serve
    start({$urandom, $urandom, $urandom, $urandom});
    repeat (3) begin @(posedge clk); #1; end
    async_reset();
    start({$urandom, $urandom, $urandom, $urandom});
    wait_expand(1'b0);
    step(0);
    step(0);
    async_reset();

    // Operation resumes after reset with a fresh enable
    start(128'h2b7e151628aed2a6abf7158809cf4f3c);
    wait_expand(1'b0);
    check_eq("post_rst_r10", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    walk_down(2);

    repeat (2) @(posedge clk);
    #1;
    check_eq("sb_drained", 128'(exp_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
